// File: rtl/conv_row_sched.sv
// conv_row_sched: row scheduler feeding three rotating line buffers and a
// 3x3 convolution engine. Streams pixels row by row into buffer 0,1,2,0,...
// and starts one convolution pass per row once three rows are resident.
// Optional build macro CONV_SCHED_WDOG_EN adds a CONV-state watchdog that
// raises a sticky conv_err and abandons the frame after TIMEOUT cycles.
module conv_row_sched #(
    parameter int unsigned ROW_W    = 100,
    parameter int unsigned NUM_ROWS = 100,
    parameter int unsigned AW       = 7,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          pix_valid,
    input  logic [7:0]    pix_data,
    output logic          pix_ready,
    output logic          lb_wr_en,
    output logic [1:0]    lb_wr_sel,
    output logic [AW-1:0] lb_wr_addr,
    output logic [7:0]    lb_wr_data,
    output logic          conv_valid,
    output logic [1:0]    conv_k,
    input  logic          conv_ready,
    output logic          busy,
    output logic          frame_done,
    output logic          conv_err
);

    localparam int unsigned RW = $clog2(NUM_ROWS);

    localparam logic [AW-1:0] COL_LAST  = AW'(ROW_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(NUM_ROWS - 1);
    localparam logic [RW-1:0] PASS_LAST = RW'(NUM_ROWS - 3);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        FLUSH,
        CONV,
        DONE
    } state_t;

    state_t          state;
    logic [AW-1:0]   col_cnt;
    logic [RW-1:0]   row_cnt;
    logic [RW-1:0]   pass_cnt;
    logic [1:0]      wr_sel;

`ifdef CONV_SCHED_WDOG_EN
    localparam int unsigned WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
    logic [WW-1:0]   wdog_cnt;
`else
    assign conv_err = 1'b0;
`endif

    // Reject parameter sets the counters and address bus cannot represent
    generate
        if (NUM_ROWS < 3 || ROW_W < 1 || (2 ** AW) < ROW_W || TIMEOUT < 1) begin : g_cfg_check
            $error("conv_row_sched: illegal parameter combination");
        end
    endgenerate

    // Handshake and status decode straight from the state register
    assign pix_ready = (state == FILL);
    assign busy      = (state != IDLE);

    // Scheduler FSM with registered line-buffer write port and engine outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            col_cnt    <= '0;
            row_cnt    <= '0;
            pass_cnt   <= '0;
            wr_sel     <= '0;
            lb_wr_en   <= 1'b0;
            lb_wr_sel  <= '0;
            lb_wr_addr <= '0;
            lb_wr_data <= '0;
            conv_valid <= 1'b0;
            conv_k     <= '0;
            frame_done <= 1'b0;
`ifdef CONV_SCHED_WDOG_EN
            wdog_cnt   <= '0;
            conv_err   <= 1'b0;
`endif
        end else begin
            lb_wr_en   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FILL;
                        col_cnt  <= '0;
                        row_cnt  <= '0;
                        pass_cnt <= '0;
                        wr_sel   <= '0;
                    end
                end
                FILL: begin
                    if (pix_valid) begin
                        lb_wr_en   <= 1'b1;
                        lb_wr_sel  <= wr_sel;
                        lb_wr_addr <= col_cnt;
                        lb_wr_data <= pix_data;
                        if (col_cnt == COL_LAST) begin
                            col_cnt <= '0;
                            // row count saturates: only "three rows resident" matters
                            if (row_cnt != ROW_LAST) begin
                                row_cnt <= row_cnt + 1'b1;
                            end
                            wr_sel <= (wr_sel == 2'd2) ? 2'd0 : wr_sel + 2'd1;
                            if (row_cnt >= RW'(2)) begin
                                state <= FLUSH;
                            end
                        end else begin
                            col_cnt <= col_cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    // next buffer to overwrite is the one holding the oldest row
                    conv_valid <= 1'b1;
                    conv_k     <= wr_sel;
                    state      <= CONV;
`ifdef CONV_SCHED_WDOG_EN
                    wdog_cnt   <= '0;
`endif
                end
                CONV: begin
                    if (conv_ready) begin
                        conv_valid <= 1'b0;
                        pass_cnt   <= pass_cnt + 1'b1;
                        if (pass_cnt == PASS_LAST) begin
                            state      <= DONE;
                            frame_done <= 1'b1;
                        end else begin
                            state <= FILL;
                        end
                    end
`ifdef CONV_SCHED_WDOG_EN
                    else if (wdog_cnt == WD_LAST) begin
                        conv_err   <= 1'b1;
                        conv_valid <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        wdog_cnt <= wdog_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_row_sched.sv
// tb_conv_row_sched: two schedulers (5-row and 3-row frames, ROW_W=4) share
// one stimulus stream; each is checked every cycle against a frame-level
// model that tracks accepted pixel count and completed passes.
module tb_conv_row_sched;

    localparam int ROW_W   = 4;
    localparam int AW      = 2;
    localparam int TIMEOUT = 16;

    logic          clk;
    logic          rst;
    logic          start;
    logic          pix_valid;
    logic [7:0]    pix_data;
    logic          conv_ready;

    logic          pr      [2];
    logic          wr_en   [2];
    logic [1:0]    wr_sel  [2];
    logic [AW-1:0] wr_addr [2];
    logic [7:0]    wr_data [2];
    logic          cv      [2];
    logic [1:0]    ck      [2];
    logic          bsy     [2];
    logic          fd      [2];
    logic          err     [2];

    int n_vec = 0;
    int n_err = 0;

    conv_row_sched #(.ROW_W(ROW_W), .NUM_ROWS(5), .AW(AW), .TIMEOUT(TIMEOUT)) dut5 (
        .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(pr[0]), .lb_wr_en(wr_en[0]), .lb_wr_sel(wr_sel[0]), .lb_wr_addr(wr_addr[0]),
        .lb_wr_data(wr_data[0]), .conv_valid(cv[0]), .conv_k(ck[0]), .conv_ready(conv_ready),
        .busy(bsy[0]), .frame_done(fd[0]), .conv_err(err[0])
    );

    conv_row_sched #(.ROW_W(ROW_W), .NUM_ROWS(3), .AW(AW), .TIMEOUT(TIMEOUT)) dut3 (
        .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(pr[1]), .lb_wr_en(wr_en[1]), .lb_wr_sel(wr_sel[1]), .lb_wr_addr(wr_addr[1]),
        .lb_wr_data(wr_data[1]), .conv_valid(cv[1]), .conv_k(ck[1]), .conv_ready(conv_ready),
        .busy(bsy[1]), .frame_done(fd[1]), .conv_err(err[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int nrows(input int i);
        return (i == 0) ? 5 : 3;
    endfunction

    // ---------------- frame-level reference model ----------------
    bit m_active [2], m_acc_on [2], m_flush [2], m_cv [2], m_done [2], m_err [2], m_wr [2];
    int m_acc [2], m_pass [2], m_wd [2], m_sel [2], m_addr [2], m_data [2], m_k [2];

    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_active[i] <= 0; m_acc_on[i] <= 0; m_flush[i] <= 0; m_cv[i] <= 0;
                m_done[i] <= 0; m_err[i] <= 0; m_wr[i] <= 0;
                m_acc[i] <= 0; m_pass[i] <= 0; m_wd[i] <= 0;
                m_sel[i] <= 0; m_addr[i] <= 0; m_data[i] <= 0; m_k[i] <= 0;
            end else begin
                m_wr[i]    <= 0;
                m_done[i]  <= 0;
                m_flush[i] <= 0;
                if (!m_active[i] && start) begin
                    m_active[i] <= 1; m_acc_on[i] <= 1; m_acc[i] <= 0; m_pass[i] <= 0;
                end
                if (m_done[i]) m_active[i] <= 0;
                if (m_acc_on[i] && pix_valid) begin
                    // pixel n of the frame lands in row n/ROW_W, buffer row%3
                    m_wr[i]   <= 1;
                    m_sel[i]  <= (m_acc[i] / ROW_W) % 3;
                    m_addr[i] <= m_acc[i] % ROW_W;
                    m_data[i] <= pix_data;
                    m_acc[i]  <= m_acc[i] + 1;
                    if ((m_acc[i] + 1) % ROW_W == 0 && (m_acc[i] + 1) / ROW_W >= m_pass[i] + 3) begin
                        m_acc_on[i] <= 0;
                        m_flush[i]  <= 1;
                    end
                end
                if (m_flush[i]) begin
                    m_cv[i] <= 1;
                    m_k[i]  <= m_pass[i] % 3;
                    m_wd[i] <= 0;
                end
                if (m_cv[i]) begin
                    if (conv_ready) begin
                        m_cv[i]   <= 0;
                        m_pass[i] <= m_pass[i] + 1;
                        if (m_pass[i] + 1 == nrows(i) - 2) m_done[i] <= 1;
                        else m_acc_on[i] <= 1;
                    end
`ifdef CONV_SCHED_WDOG_EN
                    else if (m_wd[i] + 1 == TIMEOUT) begin
                        m_err[i] <= 1; m_cv[i] <= 0; m_active[i] <= 0;
                    end else begin
                        m_wd[i] <= m_wd[i] + 1;
                    end
`endif
                end
            end
        end
    end

    // Cycle-by-cycle comparison away from the active edge
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("pix_ready[%0d]", i), pr[i], m_acc_on[i]);
            check($sformatf("busy[%0d]", i), bsy[i], m_active[i]);
            check($sformatf("wr_en[%0d]", i), wr_en[i], m_wr[i]);
            check($sformatf("conv_valid[%0d]", i), cv[i], m_cv[i]);
            check($sformatf("conv_k[%0d]", i), ck[i], m_k[i]);
            check($sformatf("frame_done[%0d]", i), fd[i], m_done[i]);
            check($sformatf("conv_err[%0d]", i), err[i], m_err[i]);
            if (m_wr[i]) begin
                check($sformatf("wr_sel[%0d]", i), wr_sel[i], m_sel[i]);
                check($sformatf("wr_addr[%0d]", i), wr_addr[i], m_addr[i]);
                check($sformatf("wr_data[%0d]", i), wr_data[i], m_data[i]);
            end
        end
    end

    // ---------------- stimulus ----------------
    int cvcnt = 0;
    bit cap = 0;
    bit cv_prev [2];
    int fd_cnt [2];
    int k_q0 [$];
    int k_q1 [$];

    // pvm: 0 gapless, 1 every other cycle, 2 random
    // crm: 0 ready 5 cycles into CONV, 1 random, 2 never, 3 as 0 plus stray pulses
    // stm: 0 no start, 1 stray starts during FILL, 2 random starts
    task automatic run(input int n, input int pvm, input int crm, input int stm);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (cv[0] || cv[1]) cvcnt++; else cvcnt = 0;
            case (pvm)
                0:       pix_valid = 1'b1;
                1:       pix_valid = c[0];
                default: pix_valid = ($urandom % 4) != 0;
            endcase
            pix_data = (pvm == 2) ? 8'($urandom) : 8'(m_acc[0] + 1);
            case (crm)
                0:       conv_ready = (cvcnt == 5);
                1:       conv_ready = ($urandom % 4) == 0;
                3:       conv_ready = (cvcnt == 5) || (c % 11 == 3 && !cv[0] && !cv[1]);
                default: conv_ready = 1'b0;
            endcase
            case (stm)
                1:       start = m_acc_on[0] && (c % 9 == 4);
                2:       start = ($urandom % 32) == 0;
                default: start = 1'b0;
            endcase
            for (int i = 0; i < 2; i++) begin
                if (cap && cv[i] && !cv_prev[i]) begin
                    if (i == 0) k_q0.push_back(int'(ck[0]));
                    else        k_q1.push_back(int'(ck[1]));
                end
                if (cap && fd[i]) fd_cnt[i]++;
                cv_prev[i] = cv[i];
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1; pix_valid = 1'b0; conv_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = '0; conv_ready = 1'b0;
        #2 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        run(4, 0, 2, 0);

        // gapless frame, pixels 1..20, engine answers 5 cycles into each pass
        cap = 1;
        pulse_start();
        run(70, 0, 0, 0);
        cap = 0;
        check("frames5", fd_cnt[0], 1);
        check("frames3", fd_cnt[1], 1);
        check("passes5", k_q0.size(), 3);
        check("passes3", k_q1.size(), 1);
        for (int p = 0; p < 3; p++)
            check($sformatf("pass%0d_k", p), (p < k_q0.size()) ? k_q0[p] : 32'hFFFF_FFFF, p);
        check("min_k", (k_q1.size() > 0) ? k_q1[0] : 32'hFFFF_FFFF, 0);

        // gapped pixels with stray start / conv_ready pulses while filling
        pulse_start();
        run(160, 1, 3, 1);

        // engine never answers
        do_reset();
        pulse_start();
        run(130, 0, 2, 0);
`ifdef CONV_SCHED_WDOG_EN
        check("wdog_err", err[0], 1'b1);
        check("wdog_cv", cv[0], 1'b0);
        check("wdog_idle", bsy[0], 1'b0);
`else
        check("hang_cv", cv[0], 1'b1);
        check("hang_busy", bsy[0], 1'b1);
`endif

        // asynchronous reset in the middle of a fill
        do_reset();
        pulse_start();
        run(6, 0, 2, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("arst_pr[%0d]", i), pr[i], 1'b0);
            check($sformatf("arst_wr[%0d]", i), {wr_en[i], wr_sel[i], wr_addr[i], wr_data[i]}, '0);
            check($sformatf("arst_cv[%0d]", i), {cv[i], ck[i]}, '0);
            check($sformatf("arst_st[%0d]", i), {bsy[i], fd[i], err[i]}, '0);
        end
        @(negedge clk);
        rst = 1'b1;
        run(5, 0, 0, 0);
        check("idle_pr", pr[0], 1'b0);

        // randomized traffic
        run(3000, 2, 1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/conv_row_sched.md
# conv_row_sched

Row scheduler for the 3×3 convolution engine and its three line buffers. Accepts the input pixel stream, writes each image row into the next line buffer in rotation, and starts one convolution pass per row once three rows are resident. Drives the engine's buffer-valid level and rotation index `k`, then waits for the engine's completion pulse before refilling. Sits between the pixel source and the line-buffer/convolution pair.

## Interface
- `ROW_W`, 100: pixels per image row (line-buffer depth)
- `NUM_ROWS`, 100: rows per frame, minimum 3
- `AW`, 7: line-buffer address width, with 2^AW ≥ ROW_W
- `TIMEOUT`, 1024: watchdog limit in cycles; used only with `CONV_SCHED_WDOG_EN`

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle frame start; honoured only in IDLE
- `pix_valid`  in  1  source has a pixel
- `pix_data`  in  8  pixel value
- `pix_ready`  out  1  block accepts a pixel; equals (state==FILL), combinational from state
- `lb_wr_en`  out  1  line-buffer write strobe
- `lb_wr_sel`  out  2  target buffer: 0, 1 or 2
- `lb_wr_addr`  out  AW  write address
- `lb_wr_data`  out  8  write data
- `conv_valid`  out  1  level; buffers hold a complete 3-row window for the engine
- `conv_k`  out  2  rotation index; names the buffer holding the oldest row
- `conv_ready`  in  1  engine pass-complete pulse
- `busy`  out  1  high in every state except IDLE
- `frame_done`  out  1  one-cycle pulse after the last pass
- `conv_err`  out  1  sticky watchdog error

## Operation
- States: IDLE, FILL, FLUSH, CONV, DONE.
- IDLE: `start`=1 → FILL. Clears the column counter, row counter, pass counter and write select.
- FILL: each accept (`pix_valid`&`pix_ready`) registers one write at the current select and address.
  - Column counter increments on each accept. At ROW_W-1 it wraps to 0, the row counter increments, and the write select rotates 0→1→2→0.
  - On the accept of the last pixel of a row: if rows filled < 3, stay in FILL; otherwise → FLUSH.
- FLUSH: lasts one cycle so the final write lands. Sets `conv_valid`=1 and → CONV.
- CONV: `conv_k` equals the write select, which is the buffer to be overwritten next and therefore holds the oldest row.
  - `conv_ready`=1 clears `conv_valid` and increments the pass counter.
  - If the pass counter was NUM_ROWS-3 → DONE; else → FILL.
- DONE: `frame_done`=1 for one cycle → IDLE.
- Ignored inputs:
  - `start` outside IDLE
  - `pix_valid` outside FILL; no accept occurs
  - `conv_ready` outside CONV
- Counter widths: the row counter and pass counter each hold NUM_ROWS-1. `conv_k` is never 3.

## Timing
- Reset values: `pix_ready` 0, `lb_wr_en` 0, `lb_wr_sel` 0, `lb_wr_addr` 0, `lb_wr_data` 0, `conv_valid` 0, `conv_k` 0, `busy` 0, `frame_done` 0, `conv_err` 0; state IDLE.
- Write latency: an accept on edge N gives `lb_wr_en`=1 during cycle N+1, with the matching sel, addr and data. Back-to-back accepts produce back-to-back writes.
- The last accept of the third or later row is on edge N. FLUSH is cycle N+1. `conv_valid` is high from cycle N+2.
- `conv_ready` sampled on edge M: `conv_valid` is low from cycle M+1, and `pix_ready` is high in cycle M+1 unless the frame is ending.
- `conv_valid` and `conv_k` are stable for the whole of CONV.
- `rst` low at any time clears all state and outputs immediately. A partially filled frame is discarded.

## Configuration
- `CONV_SCHED_WDOG_EN` defined: a counter runs in CONV.
  - On reaching TIMEOUT cycles without `conv_ready`: `conv_err`←1 (sticky until reset), `conv_valid`←0, → IDLE, with no `frame_done`.
- Undefined: no counter is built, `conv_err` is tied 0, and CONV waits indefinitely.

## Test plan
Use ROW_W=4, NUM_ROWS=5 unless stated.
- Reset: `rst` low mid-FILL → all outputs at reset values within the same cycle. After release, `pix_ready`=0 until `start`.
- Fill: `start`, then 12 pixels 1..12 with `pix_valid` always high → writes sel0 addr0..3 = 1..4, sel1 = 5..8, sel2 = 9..12. `conv_valid` rises 2 cycles after the 12th accept, with `conv_k`=0.
- Rotation: engine returns `conv_ready` 5 cycles after each `conv_valid`. Rows 4 and 5 go to sel 0 then sel 1. Passes see `conv_k` = 0, 1, 2. `frame_done` pulses once, 1 cycle after the third `conv_ready`.
- Backpressure and ignored inputs:
  - `pix_valid` held high during CONV → no writes.
  - `start` and `conv_ready` pulsed during FILL → no effect.
  - Gapped `pix_valid` (every other cycle) → same write contents as the gapless case.
- Minimum frame: NUM_ROWS=3 → exactly one pass with `conv_k`=0, then `frame_done`.
- Watchdog: with `CONV_SCHED_WDOG_EN` and TIMEOUT=16, no `conv_ready` → `conv_err`=1 and `conv_valid`=0 after 16 CONV cycles, state IDLE. Without the macro, `conv_valid` is still high after 100 cycles.
